// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the SDRAM write-port arbiter:
//   ADDR_W_DEF / DATA_W_DEF : default word address / pixel data widths
//   arbState_t              : 2-bit arbiter state encoding
//   oneHotToIdx()           : one-hot (up to 8 bits) to binary index
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 24;   // bank(2) + row(13) + col(9)
    localparam int DATA_W_DEF = 16;   // RGB565

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arbState_t;

    // Callers guarantee at most one bit set; an all-zero vector maps to 0.
    function automatic logic [2:0] oneHotToIdx(input logic [7:0] oneHot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oneHot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdram_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority encoder. Scans the request vector starting at
// rrPtr and wrapping around; the first set bit wins.
// Ports:
//   req       in   N     request vector
//   rrPtr     in   IW    index with highest priority
//   winOneHot out  N     one-hot winner (all zero when no request)
//   winIdx    out  IW    binary index of the winner
//   anyReq    out  1     at least one request present
// -----------------------------------------------------------------------------
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rrPtr,
    output logic [N-1:0]  winOneHot,
    output logic [IW-1:0] winIdx,
    output logic          anyReq
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        winOneHot = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            // Modulo keeps the scan correct for non power-of-two client counts.
            cand = IW'((int'(rrPtr) + i) % N);
            if (!found && req[cand]) begin
                winOneHot[cand] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    assign winIdx = IW'(oneHotToIdx(8'(winOneHot)));
    assign anyReq = |req;

endmodule

// File: rtl/sdram_wr_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_wr_arbiter
// Shares the single SDRAM controller write port among N_CLIENTS draw engines.
// One word per grant, round-robin between clients, with an optional per-client
// lock that keeps priority for back-to-back words.
//
// Handshake: sdram_wr_req is a level "valid" that rises one cycle after the
// registered address/data are set up and stays high until the controller
// returns a one-cycle sdram_wr_done ("ready/accepted"); the word is complete on
// the edge where both are high. sdram_wr_done is ignored in every other state.
// Clients see cli_gnt held from ISSUE through RELEASE and a one-cycle cli_done
// in RELEASE; they may change req/addr/data/lock on the edge that ends RELEASE.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              1 = new grants allowed (in-flight word always completes)
//   cli_req/lock    per-client request and lock-for-next-word
//   cli_addr/data   packed per client, client k at [k*W +: W]
//   cli_gnt         one-hot grant, held ISSUE..RELEASE
//   cli_done        one-cycle pulse per written word
//   sdram_wr_*      registered address/data/request to the controller,
//                   sdram_wr_done is the controller completion pulse
//   busy            state != IDLE
//   timeout_err     sticky WAIT watchdog flag
//   dbgState        current arbiter state (arbState_t encoding)
//
// Configuration: define SDRAM_ARB_TIMEOUT_EN to enable a 16-bit WAIT watchdog
// that abandons a word after TIMEOUT_CYCLES WAIT cycles. Without it WAIT has
// no limit and timeout_err is tied low.
// -----------------------------------------------------------------------------
module sdram_wr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int N_CLIENTS      = 4,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [N_CLIENTS-1:0]          cli_req,
    input  logic [N_CLIENTS-1:0]          cli_lock,
    input  logic [N_CLIENTS*ADDR_W-1:0]   cli_addr,
    input  logic [N_CLIENTS*DATA_W-1:0]   cli_data,
    output logic [N_CLIENTS-1:0]          cli_gnt,
    output logic [N_CLIENTS-1:0]          cli_done,
    output logic [ADDR_W-1:0]             sdram_wr_addr,
    output logic [DATA_W-1:0]             sdram_wr_data,
    output logic                          sdram_wr_req,
    input  logic                          sdram_wr_done,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [1:0]                    dbgState
);

    localparam int IW = $clog2(N_CLIENTS);

    arbState_t            state;
    logic [IW-1:0]        rrPtr;
    logic [IW-1:0]        gntIdx;
    logic [IW-1:0]        pickIdx;
    logic [IW-1:0]        nextIdx;
    logic [N_CLIENTS-1:0] pickOneHot;
    logic                 anyReq;

    rr_pick #(
        .N  (N_CLIENTS),
        .IW (IW)
    ) uPick (
        .req       (cli_req),
        .rrPtr     (rrPtr),
        .winOneHot (pickOneHot),
        .winIdx    (pickIdx),
        .anyReq    (anyReq)
    );

    // Client after the current holder, wrapping for any client count.
    assign nextIdx  = (gntIdx == IW'(N_CLIENTS - 1)) ? '0 : gntIdx + 1'b1;
    assign busy     = (state != ST_IDLE);
    assign dbgState = state;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wdCnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rrPtr         <= '0;
            gntIdx        <= '0;
            cli_gnt       <= '0;
            cli_done      <= '0;
            sdram_wr_addr <= '0;
            sdram_wr_data <= '0;
            sdram_wr_req  <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            wdCnt         <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            // cli_done is a single-cycle pulse; only WAIT raises it.
            cli_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (en && anyReq) begin
                        sdram_wr_addr <= cli_addr[pickIdx*ADDR_W +: ADDR_W];
                        sdram_wr_data <= cli_data[pickIdx*DATA_W +: DATA_W];
                        gntIdx        <= pickIdx;
                        cli_gnt       <= pickOneHot;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Address/data have had one cycle of setup; raise the request.
                    sdram_wr_req <= 1'b1;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    wdCnt        <= '0;
`endif
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion is checked first so it wins a tie with the watchdog.
                    if (sdram_wr_done) begin
                        sdram_wr_req <= 1'b0;
                        cli_done     <= cli_gnt;
                        state        <= ST_RELEASE;
                    end
`ifdef SDRAM_ARB_TIMEOUT_EN
                    else if (wdCnt == WD_LAST) begin
                        sdram_wr_req <= 1'b0;
                        cli_done     <= cli_gnt;
                        timeout_err  <= 1'b1;
                        state        <= ST_RELEASE;
                    end else begin
                        wdCnt <= wdCnt + 16'd1;
                    end
`endif
                end
                ST_RELEASE: begin
                    // A locking client keeps top priority for the next decision;
                    // if it also drops cli_req the scan simply moves past it.
                    rrPtr   <= cli_lock[gntIdx] ? gntIdx : nextIdx;
                    cli_gnt <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_wr_arbiter
// Self-checking bench for sdram_wr_arbiter: directed scenarios followed by
// randomized traffic, compared cycle by cycle against a transaction-level
// reference model and a scoreboard of words expected at the controller.
// -----------------------------------------------------------------------------
module tb_sdram_wr_arbiter;

    localparam int N   = 4;
    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int TO  = 16;
    localparam int SBW = N + AW + DW;
`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          lock;
    } word_t;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    cli_req;
    logic [N-1:0]    cli_lock;
    logic [N*AW-1:0] cli_addr;
    logic [N*DW-1:0] cli_data;
    logic [N-1:0]    cli_gnt;
    logic [N-1:0]    cli_done;
    logic [AW-1:0]   sdram_wr_addr;
    logic [DW-1:0]   sdram_wr_data;
    logic            sdram_wr_req;
    logic            sdram_wr_done;
    logic            busy;
    logic            timeout_err;
    logic [1:0]      dbgState;

    always #5 clk = ~clk;

    sdram_wr_arbiter #(
        .N_CLIENTS      (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .cli_req       (cli_req),
        .cli_lock      (cli_lock),
        .cli_addr      (cli_addr),
        .cli_data      (cli_data),
        .cli_gnt       (cli_gnt),
        .cli_done      (cli_done),
        .sdram_wr_addr (sdram_wr_addr),
        .sdram_wr_data (sdram_wr_data),
        .sdram_wr_req  (sdram_wr_req),
        .sdram_wr_done (sdram_wr_done),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .dbgState      (dbgState)
    );

    // ---------------- bench state ----------------
    int nChecks = 0;
    int nErrors = 0;
    int nWritten = 0;

    word_t          cliQ[N][$];      // pending words per client
    logic [SBW-1:0] expQ[$];         // words expected at the controller
    int             gntLog[$];       // order of grants predicted by the model
    int             expOrd[$];

    // reference model
    int            mPtr;
    bit            mActive, mReqUp, mRelease;
    int            mG, mWait;
    logic [N-1:0]  eGnt, eDone;
    logic          eReq, eTo;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eData;
    bit            sbPending, sbWritten;
    int            popClient, popDelay;

    // controller / stimulus knobs
    bit noDone, spurious, scramble;
    int ctrlDelay;

    // ---------------- checking ----------------
    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Round robin rule: first requester at or after the pointer, circularly.
    function automatic int pickRr(input logic [N-1:0] req, input int p);
        for (int k = 0; k < N; k++) begin
            if (req[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit allIdle();
        if (mActive || popClient >= 0) return 1'b0;
        for (int k = 0; k < N; k++) begin
            if (cliQ[k].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelReset();
        mPtr = 0; mActive = 0; mReqUp = 0; mRelease = 0; mG = 0; mWait = 0;
        eGnt = '0; eDone = '0; eReq = 1'b0; eTo = 1'b0; eAddr = '0; eData = '0;
        sbPending = 0; sbWritten = 0; popClient = -1; popDelay = 0;
        expQ.delete();
    endtask

    task automatic endWord(input bit written);
        eReq = 1'b0;
        eDone = '0;
        eDone[mG] = 1'b1;
        mRelease = 1;
        sbPending = 1;
        sbWritten = written;
        popClient = mG;
        popDelay = 1;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic modelEdge();
        eDone = '0;
        if (mRelease) begin
            mPtr = cli_lock[mG] ? mG : (mG + 1) % N;
            eGnt = '0;
            mActive = 0; mReqUp = 0; mRelease = 0;
        end else if (mActive && !mReqUp) begin
            mReqUp = 1; eReq = 1'b1; mWait = 0;
        end else if (mActive) begin
            if (sdram_wr_done) begin
                endWord(1'b1);
            end else begin
                mWait++;
                if (TO_EN && mWait == TO) begin
                    endWord(1'b0);
                    eTo = 1'b1;
                end
            end
        end else if (en && (|cli_req)) begin
            mG = pickRr(cli_req, mPtr);
            mActive = 1;
            eGnt = '0;
            eGnt[mG] = 1'b1;
            eAddr = cli_addr[mG*AW +: AW];
            eData = cli_data[mG*DW +: DW];
            expQ.push_back({eGnt, eAddr, eData});
            gntLog.push_back(mG);
        end
    endtask

    task automatic checkOutputs();
        logic [SBW-1:0] ent;
        checkEq("gnt", cli_gnt, eGnt);
        checkEq("done", cli_done, eDone);
        checkEq("wr_req", sdram_wr_req, eReq);
        checkEq("busy", busy, mActive);
        checkEq("wr_addr", sdram_wr_addr, eAddr);
        checkEq("wr_data", sdram_wr_data, eData);
        checkEq("timeout_err", timeout_err, eTo);
        if (sbPending) begin
            sbPending = 0;
            ent = (expQ.size() > 0) ? expQ.pop_front() : '0;
            if (sbWritten) begin
                nWritten++;
                checkEq("sb_word", {cli_gnt, sdram_wr_addr, sdram_wr_data}, ent);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic loadWord(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
        word_t w;
        w.addr = a; w.data = d; w.lock = l;
        cliQ[k].push_back(w);
    endtask

    task automatic driveInputs();
        for (int k = 0; k < N; k++) begin
            if (cliQ[k].size() > 0) begin
                cli_req[k]            = 1'b1;
                cli_addr[k*AW +: AW]  = cliQ[k][0].addr;
                cli_data[k*DW +: DW]  = cliQ[k][0].data;
                cli_lock[k]           = cliQ[k][0].lock;
            end else begin
                cli_req[k]            = 1'b0;
                cli_addr[k*AW +: AW]  = AW'($urandom);
                cli_data[k*DW +: DW]  = DW'($urandom);
                cli_lock[k]           = 1'($urandom_range(0, 1));
            end
            // The arbiter must ignore the holder's bus once it has latched the word.
            if (scramble && mActive && k == mG) begin
                cli_addr[k*AW +: AW] = AW'($urandom);
                cli_data[k*DW +: DW] = DW'($urandom);
            end
        end
    endtask

    task automatic postSample();
        if (popClient >= 0) begin
            if (popDelay == 0) begin
                if (cliQ[popClient].size() > 0) void'(cliQ[popClient].pop_front());
                popClient = -1;
            end else begin
                popDelay--;
            end
        end
        if (sdram_wr_req && !noDone) begin
            if (ctrlDelay == 0) begin
                sdram_wr_done = 1'b1;
                ctrlDelay = $urandom_range(0, 3);
            end else begin
                ctrlDelay--;
                sdram_wr_done = 1'b0;
            end
        end else begin
            sdram_wr_done = spurious && ($urandom_range(0, 7) == 0);
        end
        driveInputs();
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutputs();
        postSample();
    endtask

    // Asynchronous reset asserted away from the clock edge and checked before
    // the next edge arrives.
    task automatic applyReset();
        #2;
        sdram_wr_done = 1'b0;
        rst = 1'b1;
        modelReset();
        #1;
        checkEq("rst_wr_req", sdram_wr_req, 1'b0);
        checkEq("rst_gnt", cli_gnt, '0);
        checkEq("rst_busy", busy, 1'b0);
        checkEq("rst_done", cli_done, '0);
        checkOutputs();
        @(posedge clk);
        #1;
        checkOutputs();
        #2;
        rst = 1'b0;
        ctrlDelay = $urandom_range(0, 3);
        driveInputs();
    endtask

    task automatic drain(input string tag, input int maxCyc);
        int n;
        n = 0;
        while (!allIdle() && n < maxCyc) begin
            cycle();
            n++;
        end
        checkEq({tag, "_drained"}, allIdle(), 1'b1);
    endtask

    task automatic checkOrder(input string tag);
        checkEq({tag, "_count"}, gntLog.size(), expOrd.size());
        for (int i = 0; i < expOrd.size() && i < gntLog.size(); i++) begin
            checkEq(tag, gntLog[i], expOrd[i]);
        end
    endtask

    task automatic waitForWait(input int maxCyc);
        int n;
        n = 0;
        while (!mReqUp && n < maxCyc) begin
            cycle();
            n++;
        end
        checkEq("reach_wait", mReqUp, 1'b1);
    endtask

    // ---------------- safety net ----------------
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    // ---------------- scenarios ----------------
    initial begin
        int injected;
        int wBefore;
        rst = 1'b0; en = 1'b0; sdram_wr_done = 1'b0;
        cli_req = '0; cli_lock = '0; cli_addr = '0; cli_data = '0;
        noDone = 0; spurious = 0; scramble = 0; ctrlDelay = 0;
        modelReset();
        applyReset();
        en = 1'b1;

        // Single client, controller answers a few cycles after the request.
        gntLog.delete();
        ctrlDelay = 2;
        loadWord(0, 24'h000123, 16'hF800, 1'b0);
        driveInputs();
        cycle();
        checkEq("s1_gnt", cli_gnt, 4'b0001);
        checkEq("s1_addr", sdram_wr_addr, 24'h000123);
        checkEq("s1_data", sdram_wr_data, 16'hF800);
        checkEq("s1_req_setup", sdram_wr_req, 1'b0);
        cycle();
        checkEq("s1_req", sdram_wr_req, 1'b1);
        drain("s1", 40);

        // All clients requesting, pointer from reset, no locks.
        applyReset();
        gntLog.delete();
        wBefore = nWritten;
        for (int k = 0; k < N; k++) begin
            loadWord(k, AW'($urandom), DW'($urandom), 1'b0);
            loadWord(k, AW'($urandom), DW'($urandom), 1'b0);
        end
        driveInputs();
        drain("s2", 200);
        expOrd = '{0, 1, 2, 3, 0, 1, 2, 3};
        checkOrder("s2_order");
        checkEq("s2_written", nWritten - wBefore, 8);

        // Client 2 locks for three words while client 0 waits.
        applyReset();
        gntLog.delete();
        loadWord(2, 24'h0A0002, 16'h07E0, 1'b1);
        loadWord(2, 24'h0A0003, 16'h07E1, 1'b1);
        loadWord(2, 24'h0A0004, 16'h07E2, 1'b0);
        driveInputs();
        cycle();
        loadWord(0, 24'h0B0000, 16'h001F, 1'b0);
        driveInputs();
        drain("s3", 200);
        expOrd = '{2, 2, 2, 0};
        checkOrder("s3_order");

        // en dropped during WAIT: the word completes, nothing new is granted.
        gntLog.delete();
        loadWord(1, 24'h010101, 16'h1111, 1'b0);
        loadWord(3, 24'h030303, 16'h3333, 1'b0);
        driveInputs();
        waitForWait(10);
        en = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        checkEq("s4_grants_en0", gntLog.size(), 1);
        checkEq("s4_idle_en0", busy, 1'b0);
        checkEq("s4_c3_pending", cliQ[3].size(), 1);
        en = 1'b1;
        drain("s4", 60);
        checkEq("s4_grants_en1", gntLog.size(), 2);

        // Reset while in WAIT: request drops at once and the word is retried.
        gntLog.delete();
        noDone = 1;
        loadWord(1, 24'h1F0000, 16'hABCD, 1'b0);
        driveInputs();
        waitForWait(10);
        applyReset();
        checkEq("s5_word_kept", cliQ[1].size(), 1);
        noDone = 0;
        drain("s5", 60);
        expOrd = '{1, 1};
        checkOrder("s5_order");

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Completion on the very last allowed WAIT cycle beats the watchdog.
        applyReset();
        gntLog.delete();
        ctrlDelay = TO - 1;
        loadWord(2, 24'h222222, 16'h2222, 1'b0);
        driveInputs();
        drain("s6_tie", 60);
        checkEq("s6_tie_flag", timeout_err, 1'b0);

        // No completion ever: watchdog abandons the word, next client proceeds.
        gntLog.delete();
        noDone = 1;
        loadWord(0, 24'h000010, 16'h0010, 1'b0);
        loadWord(1, 24'h000011, 16'h0011, 1'b0);
        driveInputs();
        for (int i = 0; i < 40 && !eTo; i++) cycle();
        checkEq("s6_to_flag", timeout_err, 1'b1);
        checkEq("s6_to_req", sdram_wr_req, 1'b0);
        noDone = 0;
        drain("s6", 80);
        expOrd = '{0, 1};
        checkOrder("s6_order");
        checkEq("s6_sticky", timeout_err, 1'b1);
        applyReset();
        checkEq("s6_cleared", timeout_err, 1'b0);
`endif

        // Randomized traffic: random clients, locks, en toggles, spurious
        // completions and bus noise on the granted client.
        spurious = 1; scramble = 1;
        injected = 0;
        wBefore = nWritten;
        for (int c = 0; c < 1500; c++) begin
            if (injected < 200 && $urandom_range(0, 2) == 0) begin
                loadWord($urandom_range(0, N - 1), AW'($urandom), DW'($urandom),
                         ($urandom_range(0, 3) == 0));
                injected++;
            end
            if ($urandom_range(0, 15) == 0) en = ~en;
            driveInputs();
            cycle();
        end
        en = 1'b1;
        drain("rand", 4000);
        checkEq("rand_written", nWritten - wBefore, injected);
        checkEq("rand_sb_empty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
